// File: rtl/vend_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_payout_ctrl
// Description : Payout controller that sits behind the vending FSM. It counts
//               pending item / dime / nickel dispenses, runs one motor at a
//               time in fixed priority (item > dime > nickel), confirms each
//               dispense with a sensor pulse and traps jams in a FAULT state
//               until software clears it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: PAYOUT_GAP_EN - when defined, a GAP state keeps all motors off
//               for GAP_CYCLES cycles after each confirmed dispense.
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   vend_req, chg5_req, chg10_req    1-cycle dispense request strobes
//   item_done, nickel_done,          dispense-confirm sensor pulses
//   dime_done
//   clear_fault                      leave FAULT and flush pending counts
//   motor_item, motor_nickel,        motor enables (at most one high)
//   motor_dime
//   busy                             work pending or not in IDLE
//   fault, fault_code[1:0]           jam flag; 01 item, 10 dime, 11 nickel
// ============================================================================
module vend_payout_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 3,
  parameter int GAP_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic       chg5_req,
  input  logic       chg10_req,
  input  logic       item_done,
  input  logic       nickel_done,
  input  logic       dime_done,
  input  logic       clear_fault,
  output logic       motor_item,
  output logic       motor_nickel,
  output logic       motor_dime,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ITEM   = 3'd1,
    S_DIME   = 3'd2,
    S_NICKEL = 3'd3,
    S_FAULT  = 3'd4
`ifdef PAYOUT_GAP_EN
    ,
    S_GAP    = 3'd5
`endif
  } state_t;

  localparam logic [1:0]       CODE_NONE   = 2'b00;
  localparam logic [1:0]       CODE_ITEM   = 2'b01;
  localparam logic [1:0]       CODE_DIME   = 2'b10;
  localparam logic [1:0]       CODE_NICKEL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [15:0]      TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  // Where a confirmed dispense goes next.
`ifdef PAYOUT_GAP_EN
  localparam state_t S_AFTER_DONE = S_GAP;
`else
  localparam state_t S_AFTER_DONE = S_IDLE;
`endif

  state_t           state;
  state_t           state_nx;
  logic [1:0]       code_nx;
  logic [CNT_W-1:0] p_item;
  logic [CNT_W-1:0] p_dime;
  logic [CNT_W-1:0] p_nick;
  logic [15:0]      tmo_cnt;
  logic             tmo_hit;
  logic             item_ok;
  logic             dime_ok;
  logic             nick_ok;
  logic             flush;
  logic             in_motor_state;

  // A done pulse only counts when it matches the motor currently running.
  assign item_ok        = (state == S_ITEM)   && item_done;
  assign dime_ok        = (state == S_DIME)   && dime_done;
  assign nick_ok        = (state == S_NICKEL) && nickel_done;
  assign flush          = (state == S_FAULT)  && clear_fault;
  assign tmo_hit        = (tmo_cnt == TMO_LAST);
  assign in_motor_state = (state == S_ITEM) || (state == S_DIME) || (state == S_NICKEL);

  // Saturating up/down: a simultaneous strobe and confirm cancel out, and a
  // strobe into a full counter is dropped.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec && (c != CNT_MAX)) begin
      r = c + 1'b1;
    end else if (dec && !inc && (c != '0)) begin
      r = c - 1'b1;
    end
    return r;
  endfunction

`ifdef PAYOUT_GAP_EN
  localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      p_item     <= '0;
      p_dime     <= '0;
      p_nick     <= '0;
      tmo_cnt    <= '0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nx;
      fault_code <= code_nx;
      if (flush) begin
        p_item <= '0;
        p_dime <= '0;
        p_nick <= '0;
      end else begin
        p_item <= cnt_next(p_item, vend_req,  item_ok);
        p_dime <= cnt_next(p_dime, chg10_req, dime_ok);
        p_nick <= cnt_next(p_nick, chg5_req,  nick_ok);
      end
      // Motor states are only ever entered from a non-motor state, so
      // holding the counter at zero elsewhere clears it on entry.
      if (in_motor_state) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = fault_code;
    case (state)
      S_IDLE: begin
        if (p_item != '0) begin
          state_nx = S_ITEM;
        end else if (p_dime != '0) begin
          state_nx = S_DIME;
        end else if (p_nick != '0) begin
          state_nx = S_NICKEL;
        end
      end
      // Done is tested before timeout so a confirm in the last cycle wins.
      S_ITEM: begin
        if (item_done) begin
          state_nx = S_AFTER_DONE;
        end else if (tmo_hit) begin
          state_nx = S_FAULT;
          code_nx  = CODE_ITEM;
        end
      end
      S_DIME: begin
        if (dime_done) begin
          state_nx = S_AFTER_DONE;
        end else if (tmo_hit) begin
          state_nx = S_FAULT;
          code_nx  = CODE_DIME;
        end
      end
      S_NICKEL: begin
        if (nickel_done) begin
          state_nx = S_AFTER_DONE;
        end else if (tmo_hit) begin
          state_nx = S_FAULT;
          code_nx  = CODE_NICKEL;
        end
      end
`ifdef PAYOUT_GAP_EN
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = S_IDLE;
        end
      end
`endif
      S_FAULT: begin
        if (clear_fault) begin
          state_nx = S_IDLE;
          code_nx  = CODE_NONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from state so reset drops motors asynchronously.
  assign motor_item   = (state == S_ITEM);
  assign motor_dime   = (state == S_DIME);
  assign motor_nickel = (state == S_NICKEL);
  assign fault        = (state == S_FAULT);
  assign busy         = (state != S_IDLE) || (p_item != '0) || (p_dime != '0) || (p_nick != '0);

endmodule
`default_nettype wire

// File: tb/tb_vend_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_payout_ctrl
// Description : Self-checking bench for vend_payout_ctrl. Stimulus pushes the
//               expected dispense sequence into a queue; a monitor pops it on
//               every motor start. Directed cases cover latency, jams, flush,
//               saturation, stray confirms and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_payout_ctrl;

  localparam int TO = 8;
  localparam int CW = 3;
  localparam int GC = 4;
`ifdef PAYOUT_GAP_EN
  localparam int LOW_BETWEEN = GC + 1;
`else
  localparam int LOW_BETWEEN = 1;
`endif
  // Dispense types; numbering equals the jam fault code of each type.
  localparam int T_ITEM = 1;
  localparam int T_DIME = 2;
  localparam int T_NICK = 3;
  localparam int SAT    = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_req, chg5_req, chg10_req;
  logic       item_done, nickel_done, dime_done, clear_fault;
  logic       motor_item, motor_nickel, motor_dime, busy, fault;
  logic [1:0] fault_code;

  vend_payout_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW),
    .GAP_CYCLES    (GC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vend_req    (vend_req),
    .chg5_req    (chg5_req),
    .chg10_req   (chg10_req),
    .item_done   (item_done),
    .nickel_done (nickel_done),
    .dime_done   (dime_done),
    .clear_fault (clear_fault),
    .motor_item  (motor_item),
    .motor_nickel(motor_nickel),
    .motor_dime  (motor_dime),
    .busy        (busy),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  bit resp_en      = 1'b0;
  bit burst_active = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int active_type();
    if (motor_item)   return T_ITEM;
    if (motor_dime)   return T_DIME;
    if (motor_nickel) return T_NICK;
    return 0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int typ, input logic v);
    case (typ)
      T_ITEM:  vend_req  = v;
      T_DIME:  chg10_req = v;
      default: chg5_req  = v;
    endcase
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check({name, "_reaches_idle"}, int'(busy), 0);
  endtask

  // Monitor: pops the next expected dispense whenever a motor starts.
  initial begin : monitor
    int prev_type;
    int run_len;
    int cur;
    int nm;
    prev_type = 0;
    run_len   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_type = 0;
        run_len   = 0;
      end else begin
        nm = int'(motor_item) + int'(motor_dime) + int'(motor_nickel);
        check("at_most_one_motor", int'(nm <= 1), 1);
        cur = active_type();
        if (cur != 0 && prev_type == 0) begin
          if (exp_q.size() == 0) check("unexpected_dispense", cur, 0);
          else                   check("dispense_order", cur, exp_q.pop_front());
          run_len = 0;
        end
        if (cur != 0) begin
          run_len++;
          if (run_len == TO + 1) check("motor_on_limit", run_len, TO);
        end
        prev_type = cur;
      end
    end
  end

  // Responder: confirms the running motor after a short random delay.
  initial begin : responder
    int resp_wait;
    resp_wait = -1;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        item_done   = 1'b0;
        dime_done   = 1'b0;
        nickel_done = 1'b0;
        if (!burst_active && active_type() != 0) begin
          if (resp_wait < 0) resp_wait = $urandom_range(0, 1);
          if (resp_wait == 0) begin
            case (active_type())
              T_ITEM:  item_done   = 1'b1;
              T_DIME:  dime_done   = 1'b1;
              default: nickel_done = 1'b1;
            endcase
            resp_wait = -1;
          end else begin
            resp_wait--;
          end
        end else begin
          resp_wait = -1;
        end
      end
    end
  end

  // Jam one type, optionally fire chg5 strobes while faulted, then clear.
  task automatic jam(input int typ, input int extra);
    int highs;
    int n;
    highs = 0;
    n     = 0;
    exp_q.push_back(typ);
    set_req(typ, 1'b1);
    tick();
    set_req(typ, 1'b0);
    while (n < 4 * TO) begin
      tick();
      n++;
      if (active_type() == typ) highs++;
      else if (highs > 0) break;
    end
    check("jam_motor_cycles", highs, TO);
    check("jam_fault_set", int'(fault), 1);
    check("jam_fault_code", int'(fault_code), typ);
    if (extra > 0) begin
      chg5_req = 1'b1;
      repeat (extra) tick();
      chg5_req = 1'b0;
    end
    repeat (3) tick();
    check("jam_fault_held", int'(fault), 1);
    check("jam_code_held", int'(fault_code), typ);
    check("jam_motors_off", active_type(), 0);
    check("jam_busy", int'(busy), 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clear_fault_low", int'(fault), 0);
    check("clear_code_none", int'(fault_code), 0);
    check("clear_flushed_busy", int'(busy), 0);
    repeat (2 * TO) tick();
    check("clear_stays_idle", int'(busy), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stim
    int highs;
    int lows;
    int cnt[3];
    bit [2:0] vec[4];
    int len;
    int first;
    int t;

    rst = 1'b1;
    vend_req = 1'b0; chg5_req = 1'b0; chg10_req = 1'b0;
    item_done = 1'b0; nickel_done = 1'b0; dime_done = 1'b0; clear_fault = 1'b0;
    repeat (3) tick();
    check("rst_motor_item",   int'(motor_item),   0);
    check("rst_motor_dime",   int'(motor_dime),   0);
    check("rst_motor_nickel", int'(motor_nickel), 0);
    check("rst_busy",         int'(busy),         0);
    check("rst_fault",        int'(fault),        0);
    check("rst_fault_code",   int'(fault_code),   0);
    rst = 1'b0;
    repeat (2) tick();

    // Single item: strobe in N, count in N+1, motor N+2, confirm on 4th high.
    exp_q.push_back(T_ITEM);
    vend_req = 1'b1;
    tick();
    vend_req = 1'b0;
    check("lat_motor_n1", int'(motor_item), 0);
    check("lat_busy_n1",  int'(busy),       1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lat_motor_high", int'(motor_item), 1);
    end
    item_done = 1'b1;
    tick();
    item_done = 1'b0;
    check("done_motor_low", int'(motor_item), 0);
    wait_idle("single_item");
    check("single_item_no_fault", int'(fault), 0);

    // Jams for each type; the nickel jam also fires 9 strobes while faulted.
    jam(T_DIME, 1);
    jam(T_NICK, 9);
    jam(T_ITEM, 0);

    // Item held to its timeout cycle while 9 nickel strobes saturate the
    // nickel count; a stray dime_done during ITEM must not consume the dime.
    exp_q.push_back(T_ITEM);
    exp_q.push_back(T_DIME);
    repeat (SAT) exp_q.push_back(T_NICK);
    highs = 0;
    for (int i = 0; i < 4 * TO; i++) begin
      vend_req  = (i == 0);
      chg10_req = (i == 0);
      chg5_req  = (i < 9);
      dime_done = (highs == 3);
      item_done = (highs == TO);
      tick();
      if (item_done) break;
      if (motor_item) highs++;
    end
    vend_req = 1'b0; chg10_req = 1'b0; chg5_req = 1'b0;
    item_done = 1'b0; dime_done = 1'b0;
    check("timeout_cycle_done_motor_low", int'(motor_item), 0);
    check("timeout_cycle_done_no_fault",  int'(fault),      0);
    lows = 1;
    while (!motor_dime && lows < 4 * TO) begin
      tick();
      if (!motor_dime) lows++;
    end
    check("low_cycles_between_dispenses", lows, LOW_BETWEEN);
    resp_en = 1'b1;
    wait_idle("saturation");
    check("saturation_queue_drained", exp_q.size(), 0);
    check("saturation_no_fault", int'(fault), 0);

    // Random bursts; the model replays the priority rule over the totals.
    for (int b = 0; b < 30; b++) begin
      wait_idle("pre_batch");
      len = $urandom_range(1, 4);
      cnt = '{0, 0, 0};
      first = 0;
      for (int c = 0; c < len; c++) begin
        vec[c] = 3'($urandom);
        if (first == 0) begin
          for (int k = 0; k < 3; k++) if (first == 0 && vec[c][k]) first = k + 1;
        end
        for (int k = 0; k < 3; k++) if (vec[c][k] && cnt[k] < SAT) cnt[k]++;
      end
      // The first pick sees only the first non-empty cycle; later picks see
      // the whole burst because confirms wait until the burst has ended.
      if (first != 0) begin
        exp_q.push_back(first);
        cnt[first-1]--;
      end
      while (cnt[0] + cnt[1] + cnt[2] > 0) begin
        t = 0;
        for (int k = 0; k < 3; k++) if (t == 0 && cnt[k] > 0) t = k + 1;
        exp_q.push_back(t);
        cnt[t-1]--;
      end
      burst_active = 1'b1;
      for (int c = 0; c < len; c++) begin
        vend_req  = vec[c][0];
        chg10_req = vec[c][1];
        chg5_req  = vec[c][2];
        tick();
      end
      vend_req = 1'b0; chg10_req = 1'b0; chg5_req = 1'b0;
      burst_active = 1'b0;
      wait_idle("batch");
      check("batch_queue_drained", exp_q.size(), 0);
      check("batch_no_fault", int'(fault), 0);
    end

    // Asynchronous reset while the nickel motor runs.
    resp_en = 1'b0;
    tick();
    item_done = 1'b0; dime_done = 1'b0; nickel_done = 1'b0;
    exp_q.push_back(T_NICK);
    chg5_req = 1'b1;
    tick();
    chg5_req = 1'b0;
    tick();
    check("pre_reset_nickel_on", int'(motor_nickel), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_nickel_off", int'(motor_nickel), 0);
    check("async_rst_busy",       int'(busy),         0);
    check("async_rst_fault",      int'(fault),        0);
    check("async_rst_code",       int'(fault_code),   0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2 * TO) tick();
    check("post_reset_idle", int'(busy), 0);
    check("post_reset_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_payout_ctrl.md
# vend_payout_ctrl

- Payout controller downstream of the vending FSM; consumes its single-cycle `vend`, `change_5C` and `change_10C` strobes.
- Queues those strobes as pending item and coin dispenses.
- Drives the item motor and the nickel and dime hopper motors one at a time, and confirms each dispense with a sensor pulse.
- Detects jams by timeout and holds in a fault state until software clears it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000 — maximum motor-on cycles per dispense; legal range 2 to 65535.
- `CNT_W`, default 3 — width of each pending counter.
- `GAP_CYCLES`, default 4 — motor-off cycles between dispenses; used only with `PAYOUT_GAP_EN`; legal range ≥ 1.

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `vend_req` in 1 — one item to dispense (1-cycle strobe).
- `chg5_req` in 1 — one nickel to dispense (1-cycle strobe).
- `chg10_req` in 1 — one dime to dispense (1-cycle strobe).
- `item_done` in 1 — item-drop sensor pulse.
- `nickel_done` in 1 — nickel-out sensor pulse.
- `dime_done` in 1 — dime-out sensor pulse.
- `clear_fault` in 1 — leave FAULT and flush all queues.
- `motor_item` out 1 — item motor enable.
- `motor_nickel` out 1 — nickel hopper enable.
- `motor_dime` out 1 — dime hopper enable.
- `busy` out 1 — high when any pending count is nonzero or state ≠ IDLE.
- `fault` out 1 — high in FAULT.
- `fault_code` out 2 — 00 none, 01 item jam, 10 dime jam, 11 nickel jam.

## Operation
Pending counters (`p_item`, `p_dime`, `p_nick`, each `CNT_W` bits):
- Each counter is +1 on its request strobe and −1 on a confirmed dispense of its type.
- A strobe and a confirm in the same cycle leave the count unchanged.
- Counts saturate at 2^CNT_W−1; extra strobes are dropped silently.
- Requests are accepted in every state, including FAULT.

States:
- IDLE
  - Selects by fixed priority: `p_item` ≠ 0 goes to ITEM, else `p_dime` ≠ 0 goes to DIME, else `p_nick` ≠ 0 goes to NICKEL.
  - Otherwise remains in IDLE.
- ITEM / DIME / NICKEL
  - The matching motor is high.
  - The timeout counter clears on entry and increments every cycle in the state.
  - The matching `*_done` pulse decrements that pending count and moves to GAP, or to IDLE without `PAYOUT_GAP_EN`.
  - When the timeout counter equals `TIMEOUT_CYCLES`−1 with no done pulse, the block moves to FAULT and latches the code.
  - A done pulse in the timeout cycle wins; no fault is raised.
- GAP
  - All motors are low for `GAP_CYCLES` cycles, then the block returns to IDLE.
- FAULT
  - All motors are low; `fault`=1 and `fault_code` holds.
  - The pending count of the jammed type is not decremented.
  - `clear_fault`=1 moves to IDLE, zeros all three pending counters and sets `fault_code`=00.
  - `clear_fault` in any other state is ignored.

Other rules:
- A `*_done` pulse that does not match the active state, including one arriving in IDLE, GAP or FAULT, is ignored.
- Outputs are Moore, decoded from state only. At most one motor is high in any cycle.

## Timing
- Reset values: state IDLE; all counters 0; all motors 0; `busy`, `fault` and `fault_code` all 0.
- Reset asserted mid-dispense drops the motor at once, asynchronously.
- Request latency: strobe in cycle N makes the count visible in N+1; if the block is IDLE, the motor is high from cycle N+2.
- Done latency: a done pulse in cycle M makes the motor low and the count decremented in cycle M+1.
- A motor stays high for at most `TIMEOUT_CYCLES` cycles. On timeout, `fault` rises in the cycle after the last motor-high cycle.
- `clear_fault` sampled in cycle K puts the block in IDLE with `fault`=0 in cycle K+1.
- Back-to-back dispenses have `GAP_CYCLES`+1 motor-low cycles between them with `PAYOUT_GAP_EN`, and exactly 1 (the IDLE cycle) without.

## Configuration
- `PAYOUT_GAP_EN` defined: the GAP state and `GAP_CYCLES` are compiled in.
- `PAYOUT_GAP_EN` undefined: the GAP state is absent, confirmed dispenses return directly to IDLE, and `GAP_CYCLES` is unused.

## Test plan
- Reset, then pulse `vend_req` at cycle 10 and `item_done` at cycle 15 → `motor_item` high for cycles 12–15 and low at 16; `busy` returns to 0 after GAP/IDLE.
- Pulse `vend_req`, `chg10_req` and `chg5_req` in one cycle, then answer every motor within 3 cycles → order is item, dime, nickel; never two motors high at once; all counts end at 0.
- Use `TIMEOUT_CYCLES`=8 and pulse `chg10_req` with no `dime_done` → `motor_dime` high for exactly 8 cycles, then `fault`=1 and `fault_code`=10. Pulse `chg5_req` and `clear_fault` → IDLE, `fault_code`=00, all counts 0, `busy`=0.
- With `CNT_W`=3, pulse `chg5_req` 9 times while held in FAULT, then clear → counts flushed. Repeat the 9 pulses without a fault → exactly 7 nickel dispenses.
- Pulse `dime_done` during ITEM, and `item_done` in the exact timeout cycle → the stray `dime_done` is ignored and the item confirms with no fault.
- Assert `rst` while `motor_nickel` is high → motor low immediately; all outputs at reset values.
